// File: rtl/mem_wb_writeback_unit.sv
// MEM/WB pipeline register with sub-word load alignment and write-back select.
// Also flags misaligned loads and counts retired instructions.
module mem_wb_writeback_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int BIG_ENDIAN     = 1,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      InValid,
    input  logic                      InRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] InWriteRegister,
    input  logic [1:0]                InResultSel,
    input  logic [1:0]                InLoadSize,
    input  logic                      InLoadUnsigned,
    input  logic [DATA_WIDTH-1:0]     InALUResult,
    input  logic [DATA_WIDTH-1:0]     InDataMemoryOut,
    input  logic [DATA_WIDTH-1:0]     InLinkPC,
    output logic [DATA_WIDTH-1:0]     WriteBackResult,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegister,
    output logic                      RegWriteEnable,
    output logic                      WBValid,
    output logic                      AlignmentFault,
    output logic [COUNT_WIDTH-1:0]    RetiredCount
);

    logic                      r_valid;
    logic                      r_reg_write;
    logic [REG_ADDR_WIDTH-1:0] r_wreg;
    logic [1:0]                r_sel;
    logic [1:0]                r_size;
    logic                      r_unsigned;
    logic [DATA_WIDTH-1:0]     r_alu;
    logic [DATA_WIDTH-1:0]     r_mem;
    logic [DATA_WIDTH-1:0]     r_link;
    logic [COUNT_WIDTH-1:0]    r_count;

    logic [1:0]            w_off;
    logic [1:0]            w_eff_off;
    logic [1:0]            w_lane;
    logic                  w_hlane;
    logic                  w_is_load;
    logic                  w_half;
    logic                  w_byte;
    logic                  w_word;
    logic                  w_fault;
    logic [7:0]            w_byte_val;
    logic [15:0]           w_half_val;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic                  w_advance;

    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_wreg      <= '0;
            r_sel       <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_alu       <= '0;
            r_mem       <= '0;
            r_link      <= '0;
        end else if (!Stall) begin
            r_valid     <= InValid;
            r_reg_write <= InRegWrite;
            r_wreg      <= InWriteRegister;
            r_sel       <= InResultSel;
            r_size      <= InLoadSize;
            r_unsigned  <= InLoadUnsigned;
            r_alu       <= InALUResult;
            r_mem       <= InDataMemoryOut;
            r_link      <= InLinkPC;
        end
    end

    // The WB instruction leaves the stage (retires) unless a pure stall holds it.
    assign w_advance = !Stall || Flush;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count <= '0;
        end else if (r_valid && w_advance) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign w_off     = r_alu[1:0];
    assign w_is_load = (r_sel == 2'b01);
    assign w_half    = (r_size == 2'b01);
    assign w_byte    = (r_size == 2'b10);
    assign w_word    = (r_size == 2'b00) || (r_size == 2'b11);
    assign w_fault   = r_valid && w_is_load &&
                       ((w_half && w_off[0]) || (w_word && (w_off != 2'b00)));

    // Misaligned loads fall back to offset-0 extraction.
    assign w_eff_off = w_fault ? 2'b00 : w_off;
    assign w_lane    = (BIG_ENDIAN != 0) ? ~w_eff_off : w_eff_off;
    assign w_hlane   = (BIG_ENDIAN != 0) ? ~w_eff_off[1] : w_eff_off[1];

    assign w_byte_val = r_mem[{w_lane, 3'b000} +: 8];
    assign w_half_val = r_mem[{w_hlane, 4'b0000} +: 16];

    always_comb begin
        w_load_val = r_mem;
        if (w_byte) begin
            w_load_val = {{(DATA_WIDTH-8){~r_unsigned & w_byte_val[7]}},
                          w_byte_val};
        end else if (w_half) begin
            w_load_val = {{(DATA_WIDTH-16){~r_unsigned & w_half_val[15]}},
                          w_half_val};
        end
    end

    always_comb begin
        case (r_sel)
            2'b01:   WriteBackResult = w_load_val;
            2'b10:   WriteBackResult = r_link;
            default: WriteBackResult = r_alu;
        endcase
    end

    assign WriteRegister  = r_wreg;
    assign WBValid        = r_valid;
    assign AlignmentFault = w_fault;
    assign RegWriteEnable = r_valid && r_reg_write &&
                            (r_wreg != '0) && !w_fault;
    assign RetiredCount   = r_count;

endmodule
